// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file write arbiter.
//   wr_port_t : one write-port bundle {addr, data, en} at the default widths.
//   next_idx  : modulo-n increment used for round-robin pointer walks.
package regfile_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned N_REG_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(N_REG_DEF);

  typedef struct packed {
    logic [AW_DEF-1:0]    addr;
    logic [WIDTH_DEF-1:0] data;
    logic                 en;
  } wr_port_t;

  // (idx + 1) mod n, for idx < n
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/regfile_wr_grant_scan.sv
// Combinational round-robin grant scan for the register file write arbiter.
//   valid    : requesters with a pending write (already gated by reset)
//   addr     : per-requester destination register
//   rr_ptr   : first requester visited this cycle
//   grant    : per-requester ready (includes out-of-range drops)
//   port_src : requester driving each write port
//   port_vld : write port assigned this cycle
//   last_idx : index of the last granted requester in scan order
//   any_grant: at least one requester granted
//   drop     : an out-of-range request was granted and discarded
module regfile_wr_grant_scan
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned N_WPORTS = 2,
  parameter int unsigned N_REG    = 32,
  parameter int unsigned AW       = 5,
  localparam int unsigned IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]              valid,
  input  logic [N_REQ-1:0][AW-1:0]      addr,
  input  logic [IW-1:0]                 rr_ptr,
  output logic [N_REQ-1:0]              grant,
  output logic [N_WPORTS-1:0][IW-1:0]   port_src,
  output logic [N_WPORTS-1:0]           port_vld,
  output logic [IW-1:0]                 last_idx,
  output logic                          any_grant,
  output logic                          drop
);

  logic [N_WPORTS-1:0][AW-1:0] port_addr;
  logic [IW-1:0]               idx;
  logic                        clash;
  logic                        taken;

  // Visit each requester once starting at rr_ptr; lower scan position wins conflicts.
  always_comb begin
    grant     = '0;
    port_src  = '0;
    port_vld  = '0;
    port_addr = '0;
    last_idx  = rr_ptr;
    any_grant = 1'b0;
    drop      = 1'b0;
    idx       = rr_ptr;
    clash     = 1'b0;
    taken     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      // once every port is used nothing further is granted, drops included
      if (valid[idx] && !(&port_vld)) begin
        if ({1'b0, addr[idx]} >= (AW+1)'(N_REG)) begin
          grant[idx] = 1'b1;
          drop       = 1'b1;
          any_grant  = 1'b1;
          last_idx   = idx;
        end else begin
          clash = 1'b0;
          for (int p = 0; p < N_WPORTS; p++) begin
            if (port_vld[p] && (port_addr[p] == addr[idx])) clash = 1'b1;
          end
          if (!clash) begin
            taken = 1'b0;
            for (int p = 0; p < N_WPORTS; p++) begin
              if (!taken && !port_vld[p]) begin
                port_vld[p]  = 1'b1;
                port_src[p]  = idx;
                port_addr[p] = addr[idx];
                taken        = 1'b1;
              end
            end
            grant[idx] = 1'b1;
            any_grant  = 1'b1;
            last_idx   = idx;
          end
        end
      end
      idx = IW'(next_idx(32'(idx), N_REQ));
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register file write-port arbiter: round-robin selection of up to N_WPORTS
// write requests per cycle from N_REQ valid/ready producers, with no two ports
// writing the same address in one cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : requester has a write pending
//   req_ready  : requester granted this cycle (combinational)
//   req_addr   : destination register per requester
//   req_data   : write data per requester
//   waddr/wen/wdata : registered register file write ports
//   drop_err   : one-cycle pulse after an out-of-range request was accepted
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned N_REG    = N_REG_DEF,
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned N_WPORTS = 2,
  localparam int unsigned AW      = $clog2(N_REG)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0][AW-1:0]         req_addr,
  input  logic [N_REQ-1:0][WIDTH-1:0]      req_data,
  output logic [N_WPORTS-1:0][AW-1:0]      waddr,
  output logic [N_WPORTS-1:0]              wen,
  output logic [N_WPORTS-1:0][WIDTH-1:0]   wdata,
  output logic                             drop_err
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]               rr_ptr;
  logic [IW-1:0]               last_idx;
  logic [N_WPORTS-1:0][IW-1:0] port_src;
  logic [N_WPORTS-1:0]         port_vld;
  logic [N_REQ-1:0]            grant;
  logic [N_REQ-1:0]            scan_valid;
  logic                        any_grant;
  logic                        drop;

  // No grants while in reset: an accepted write would be discarded anyway.
  assign scan_valid = req_valid & {N_REQ{rst_n}};
  assign req_ready  = grant;

  regfile_wr_grant_scan #(
    .N_REQ   (N_REQ),
    .N_WPORTS(N_WPORTS),
    .N_REG   (N_REG),
    .AW      (AW)
  ) u_scan (
    .valid    (scan_valid),
    .addr     (req_addr),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .port_src (port_src),
    .port_vld (port_vld),
    .last_idx (last_idx),
    .any_grant(any_grant),
    .drop     (drop)
  );

  // Output ports and round-robin pointer; idle ports keep their last addr/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      wen      <= '0;
      waddr    <= '0;
      wdata    <= '0;
      drop_err <= 1'b0;
    end else begin
      wen      <= port_vld;
      drop_err <= drop;
      for (int p = 0; p < N_WPORTS; p++) begin
        if (port_vld[p]) begin
          waddr[p] <= req_addr[port_src[p]];
          wdata[p] <= req_data[port_src[p]];
        end
      end
      if (any_grant) rr_ptr <= IW'(next_idx(32'(last_idx), N_REQ));
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by a
// randomized valid/ready phase, all checked against a behavioural model.
// Two instances: u0 (N_REG=20, 4 requesters, 2 ports), u1 (same, 1 port).
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst_n;

  logic [3:0]       v0, v1;
  logic [3:0]       ready0, ready1;
  logic [3:0][4:0]  a0, a1;
  logic [3:0][31:0] d0, d1;

  logic [1:0][4:0]  waddr0;
  logic [1:0]       wen0;
  logic [1:0][31:0] wdata0;
  logic             drop0;
  logic [0:0][4:0]  waddr1;
  logic [0:0]       wen1;
  logic [0:0][31:0] wdata1;
  logic             drop1;

  regfile_wr_arbiter #(.WIDTH(32), .N_REG(20), .N_REQ(4), .N_WPORTS(2)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(ready0),
    .req_addr(a0), .req_data(d0), .waddr(waddr0), .wen(wen0),
    .wdata(wdata0), .drop_err(drop0)
  );

  regfile_wr_arbiter #(.WIDTH(32), .N_REG(20), .N_REQ(4), .N_WPORTS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1),
    .req_addr(a1), .req_data(d1), .waddr(waddr1), .wen(wen1),
    .wdata(wdata1), .drop_err(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state: round-robin start and expected port registers
  int               rr0, rr1;
  logic [1:0]       e_wen0, e_wen1;
  logic [1:0][4:0]  e_wa0, e_wa1;
  logic [1:0][31:0] e_wd0, e_wd1;
  logic             e_drop0, e_drop1;
  logic [3:0]       g0, g1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr0 = 0; rr1 = 0;
    e_wen0 = '0; e_wa0 = '0; e_wd0 = '0; e_drop0 = 1'b0;
    e_wen1 = '0; e_wa1 = '0; e_wd1 = '0; e_drop1 = 1'b0;
  endtask

  // One arbitration cycle from the rules: walk requesters from rr, drop
  // out-of-range ones, skip addresses already taken, fill ports in order.
  task automatic model(input logic [3:0] v, input logic [3:0][4:0] a,
                       input logic [3:0][31:0] d, input int np, inout int rr,
                       output logic [3:0] g, output logic [1:0] en,
                       inout logic [1:0][4:0] wa, inout logic [1:0][31:0] wd,
                       output logic drp);
    int used;
    int last;
    int taken[$];
    bit clash;
    g = '0; en = '0; drp = 1'b0; used = 0; last = -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (rr + k) % 4;
      if (v[i] && used < np) begin
        if (int'(a[i]) >= 20) begin
          g[i] = 1'b1; drp = 1'b1; last = i;
        end else begin
          clash = 1'b0;
          foreach (taken[j]) if (taken[j] == int'(a[i])) clash = 1'b1;
          if (!clash) begin
            g[i] = 1'b1;
            en[used] = 1'b1;
            wa[used] = a[i];
            wd[used] = d[i];
            taken.push_back(int'(a[i]));
            used++;
            last = i;
          end
        end
      end
    end
    if (last >= 0) rr = (last + 1) % 4;
  endtask

  // Called at posedge+1 with inputs set; checks ready, then outputs after the edge.
  task automatic step(input bit hs);
    logic [3:0] eg0, eg1;
    model(v0, a0, d0, 2, rr0, eg0, e_wen0, e_wa0, e_wd0, e_drop0);
    model(v1, a1, d1, 1, rr1, eg1, e_wen1, e_wa1, e_wd1, e_drop1);
    #2;
    g0 = ready0;
    g1 = ready1;
    chk("ready0", 64'(ready0), 64'(eg0));
    chk("ready1", 64'(ready1), 64'(eg1));
    @(posedge clk);
    #1;
    chk("wen0", 64'(wen0), 64'(e_wen0));
    chk("drop0", 64'(drop0), 64'(e_drop0));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("waddr0[%0d]", p), 64'(waddr0[p]), 64'(e_wa0[p]));
      chk($sformatf("wdata0[%0d]", p), 64'(wdata0[p]), 64'(e_wd0[p]));
    end
    chk("wen1", 64'(wen1), 64'(e_wen1[0]));
    chk("drop1", 64'(drop1), 64'(e_drop1));
    chk("waddr1", 64'(waddr1[0]), 64'(e_wa1[0]));
    chk("wdata1", 64'(wdata1[0]), 64'(e_wd1[0]));
    if (hs) begin
      v0 = v0 & ~eg0;
      v1 = v1 & ~eg1;
    end
  endtask

  initial begin
    int c;
    bit seen;
    rst_n = 1'b0;
    v0 = 4'b1111; v1 = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a0[i] = 5'(i + 1);
      d0[i] = $urandom;
      a1[i] = '0;
      d1[i] = '0;
    end
    model_reset();

    // reset with requests pending
    #1;
    chk("rst_ready", 64'(ready0), 64'd0);
    chk("rst_wen", 64'(wen0), 64'd0);
    chk("rst_drop", 64'(drop0), 64'd0);
    @(posedge clk); #1;
    chk("rst_ready_b", 64'(ready0), 64'd0);
    chk("rst_waddr", 64'(waddr0), 64'd0);
    rst_n = 1'b1;
    v0 = 4'b0000;

    // idle
    for (int i = 0; i < 3; i++) step(1'b0);

    // full load, held valid: {0,1},{2,3},{0,1}
    v0 = 4'b1111;
    step(1'b0);
    chk("full_first", 64'(g0), 64'b0011);
    step(1'b0);
    chk("full_second", 64'(g0), 64'b1100);
    step(1'b0);
    chk("full_wen", 64'(wen0), 64'b11);

    // mid-stream reset while both ports write
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", 64'(wen0), 64'd0);
    chk("mid_rst_ready", 64'(ready0), 64'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold", 64'(wen0), 64'd0);
    rst_n = 1'b1;
    model_reset();
    step(1'b0);
    chk("restart_scan", 64'(g0), 64'b0011);
    step(1'b0);

    // same-address conflict from rr_ptr=0
    v0 = 4'b0111;
    a0[0] = 5'd5; a0[1] = 5'd5; a0[2] = 5'd6;
    step(1'b1);
    chk("conf_grant", 64'(g0), 64'b0101);
    chk("conf_wen", 64'(wen0), 64'b11);
    chk("conf_p0", 64'(waddr0[0]), 64'd5);
    chk("conf_p1", 64'(waddr0[1]), 64'd6);
    step(1'b1);
    chk("retry_grant", 64'(g0), 64'b0010);
    chk("retry_wen", 64'(wen0), 64'b01);
    chk("retry_p0", 64'(waddr0[0]), 64'd5);

    // out-of-range request alone
    v0 = 4'b1000;
    a0[3] = 5'd25;
    step(1'b1);
    chk("oor_grant", 64'(g0), 64'b1000);
    chk("oor_drop", 64'(drop0), 64'd1);
    chk("oor_wen", 64'(wen0), 64'd0);
    step(1'b1);
    chk("oor_pulse", 64'(drop0), 64'd0);

    // fairness on the single-port instance, req0 and req3 held valid
    v1 = 4'b1001;
    a1[0] = 5'd3; a1[3] = 5'd9;
    d1[0] = $urandom; d1[3] = $urandom;
    c = 0; seen = 1'b0;
    while (!seen && c < 4) begin
      step(1'b0);
      c++;
      if (g1[3]) seen = 1'b1;
    end
    chk("fair_seen", 64'(seen), 64'd1);
    chk("fair_latency", 64'(c), 64'd2);
    step(1'b0);
    chk("fair_wrap", 64'(g1), 64'b0001);
    chk("fair_data", 64'(wdata1[0]), 64'(d1[0]));
    v1 = 4'b0000;
    step(1'b0);

    // randomized producers obeying valid/ready
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!v0[i] && ($urandom_range(1, 0) == 1)) begin
          v0[i] = 1'b1;
          a0[i] = ($urandom_range(9, 0) == 0) ? 5'(20 + $urandom_range(11, 0))
                                              : 5'($urandom_range(7, 0));
          d0[i] = $urandom;
        end
        if (!v1[i] && ($urandom_range(3, 0) == 0)) begin
          v1[i] = 1'b1;
          a1[i] = 5'($urandom_range(23, 0));
          d1[i] = $urandom;
        end
      end
      step(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
